alu_arbiter: RTL and testbench

//  Shares the single combinational 8-bit ALU between two requesters (req0, req1).

---
 rtl/alu_pkg.sv | 12 +
 rtl/rr_arb2.sv | 10 +
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared defaults and FSM encoding for the ALU arbiter slice.
package alu_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SELW_DEF  = 4;
  localparam int CNTW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; a lone requester always wins,
// and on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, execute, respond.
// Accept edge -> response valid 2 cycles later; result held until the owner takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SELW-1:0]  req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SELW-1:0]  req1_sel,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);
  state_t     state, state_nx;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;
  logic       accept;
  logic       done;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (|grant) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        // Only the owner's ready completes the response; the other side is ignored.
        if (owner ? rsp1_ready : rsp0_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
      ops_done   <= '0;
    end else begin
      state <= state_nx;
      // Operand registers drive the ALU directly and keep their value until the next accept.
      if (accept) begin
        owner   <= grant[1];
        alu_a   <= grant[1] ? req1_a   : req0_a;
        alu_b   <= grant[1] ? req1_b   : req0_b;
        alu_sel <= grant[1] ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_cout <= alu_cout;
      end
      if (done) begin
        last_grant <= owner;
        ops_done   <= ops_done + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural ALU in the loop; counter narrowed to 4 bits for wrap.
module tb_alu_arbiter;
  localparam int W = 8;
  localparam int S = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [S-1:0] req0_sel, req1_sel;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic         rsp_cout, alu_cout, busy;
  logic [S-1:0] alu_sel;
  logic [C-1:0] ops_done;

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [S-1:0] s);
    case (s)
      4'h0:    return {1'b0, a};
      4'h1:    return {1'b0, a} + {1'b0, b};
      4'h2:    return {1'b0, a} - {1'b0, b};
      4'h3:    return {1'b0, a & b};
      4'h4:    return {1'b0, a | b};
      4'h5:    return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  assign {alu_cout, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  alu_arbiter #(.WIDTH(W), .SELW(S), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    exp_ops = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 00000",
                        {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    tests++;
    if ({alu_a, alu_b, alu_sel, rsp_data, rsp_cout, ops_done} !== '0) begin
      fails++; $display("FAIL reset_data a=%h b=%h sel=%h d=%h c=%b ops=%0d want all 0",
                        alu_a, alu_b, alu_sel, rsp_data, rsp_cout, ops_done);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h04; req0_sel = 4'h1; rsp0_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin fails++; $display("FAIL single_accept got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0; req0_a = 8'hEE; req0_b = 8'hDD; req0_sel = 4'h3;
    #1;
    tests++;
    if ({busy, rsp0_valid, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 8'h05, 8'h04, 4'h1}) begin
      fails++; $display("FAIL single_exec busy=%b v=%b a=%h b=%h sel=%h want 1 0 05 04 1",
                        busy, rsp0_valid, alu_a, alu_b, alu_sel);
    end
    @(negedge clk); #1;
    tests++;
    if ({rsp0_valid, rsp1_valid, rsp_data, rsp_cout} !== {2'b10, 8'h09, 1'b0}) begin
      fails++; $display("FAIL single_rsp v0=%b v1=%b d=%h c=%b want 1 0 09 0",
                        rsp0_valid, rsp1_valid, rsp_data, rsp_cout);
    end
    @(negedge clk); #1;
    exp_ops = 1;
    tests++;
    if ({busy, rsp0_valid} !== 2'b00 || ops_done !== C'(exp_ops)) begin
      fails++; $display("FAIL single_done busy=%b v0=%b ops=%0d want 0 0 %0d",
                        busy, rsp0_valid, ops_done, exp_ops);
    end
    rsp0_ready = 0;
  endtask

  task automatic test_alternate();
    int n;
    int eg;
    do_reset();
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h04; req0_sel = 4'h2;
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h01; req1_sel = 4'h1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 3; k++) begin
      eg = k % 2;
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 8) begin
        @(negedge clk); #1; n++;
      end
      tests++;
      if ({req1_ready, req0_ready} !== (eg == 1 ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL alt_grant%0d got %b want req%0d", k, {req1_ready, req0_ready}, eg);
      end
      @(negedge clk); @(negedge clk); #1;
      tests++;
      if (eg == 0 && {rsp1_valid, rsp0_valid, rsp_data, rsp_cout} !== {2'b01, 8'h01, 1'b0}) begin
        fails++; $display("FAIL alt_rsp%0d v=%b d=%h c=%b want 01 01 0",
                          k, {rsp1_valid, rsp0_valid}, rsp_data, rsp_cout);
      end else if (eg == 1 && {rsp1_valid, rsp0_valid, rsp_data, rsp_cout} !== {2'b10, 8'h00, 1'b1}) begin
        fails++; $display("FAIL alt_rsp%0d v=%b d=%h c=%b want 10 00 1",
                          k, {rsp1_valid, rsp0_valid}, rsp_data, rsp_cout);
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    exp_ops = 3;
    tests++;
    if (ops_done !== C'(exp_ops)) begin
      fails++; $display("FAIL alt_ops got %0d want %0d", ops_done, exp_ops);
    end
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    req0_valid = 1; req0_a = 8'h3C; req0_b = 8'h0F; req0_sel = 4'h5; rsp0_ready = 0;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin fails++; $display("FAIL hold_accept got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_a = 8'h10; req1_b = 8'h20; req1_sel = 4'h4; rsp1_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({rsp0_valid, rsp1_valid, req1_ready, rsp_data} !== {3'b100, 8'h33}) begin
        fails++; $display("FAIL hold_stall%0d v0=%b v1=%b r1=%b d=%h want 1 0 0 33",
                          i, rsp0_valid, rsp1_valid, req1_ready, rsp_data);
      end
      @(negedge clk);
    end
    rsp0_ready = 1;
    #1;
    tests++;
    if (req1_ready !== 1'b0) begin fails++; $display("FAIL hold_notyet got %b want 0", req1_ready); end
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    tests++;
    if (req1_ready !== 1'b1) begin fails++; $display("FAIL hold_next_grant got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk); #1;
    tests++;
    if ({rsp1_valid, rsp0_valid, rsp_data} !== {2'b10, 8'h30}) begin
      fails++; $display("FAIL hold_rsp1 v=%b d=%h want 10 30", {rsp1_valid, rsp0_valid}, rsp_data);
    end
    @(negedge clk); #1;
    exp_ops = exp_ops + 2;
    tests++;
    if (ops_done !== C'(exp_ops)) begin
      fails++; $display("FAIL hold_ops got %0d want %0d", ops_done, exp_ops);
    end
    rsp1_ready = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02; req1_sel = 4'h1; rsp1_ready = 1;
    @(negedge clk);
    req1_valid = 0;
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL midrst_exec busy=%b want 1", busy); end
    #1 rst_n = 0;
    #1;
    tests++;
    if ({busy, rsp1_valid, rsp0_valid} !== 3'b0 || {alu_a, alu_b, alu_sel, ops_done} !== '0) begin
      fails++; $display("FAIL midrst_clear busy=%b v=%b a=%h ops=%0d want all 0",
                        busy, {rsp1_valid, rsp0_valid}, alu_a, ops_done);
    end
    @(negedge clk);
    rst_n = 1;
    exp_ops = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if ({rsp1_valid, rsp0_valid, busy} !== 3'b0) begin
        fails++; $display("FAIL midrst_norsp%0d v=%b busy=%b want 0", i, {rsp1_valid, rsp0_valid}, busy);
      end
    end
    rsp1_ready = 0;
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk);
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_sel = 4'h1; rsp0_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      #1;
      while (!req0_ready && n < 8) begin
        @(negedge clk); #1; n++;
      end
      tests++;
      if (!req0_ready || ops_done !== C'((exp_ops + i) % 16)) begin
        fails++; $display("FAIL wrap_op%0d ready=%b ops=%0d want 1 %0d",
                          i, req0_ready, ops_done, (exp_ops + i) % 16);
      end
      repeat (3) @(negedge clk);
    end
    req0_valid = 0;
    #1;
    exp_ops = (exp_ops + 16) % 16;
    tests++;
    if (ops_done !== C'(exp_ops)) begin
      fails++; $display("FAIL wrap_final got %0d want %0d", ops_done, exp_ops);
    end
    rsp0_ready = 0;
  endtask

  // Reference: an operation is outstanding for two cycles after acceptance, then waits
  // for its owner; ties go to whoever was not served last.
  task automatic test_random();
    bit        pend[2];
    logic [W-1:0] pa[2], pb[2];
    logic [S-1:0] ps[2];
    int        phase = 0;
    int        own = 0;
    int        mlast = 0;
    int        eg;
    logic [W:0] expv = '0;
    logic [W-1:0] ca = '0, cb = '0;
    logic [S-1:0] cs = '0;
    bit        rdy0, rdy1;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1) begin
          pend[r] = 1;
          pa[r] = W'($urandom); pb[r] = W'($urandom); ps[r] = S'($urandom_range(7, 0));
        end
      end
      req0_valid = pend[0]; req1_valid = pend[1];
      req0_a = pend[0] ? pa[0] : W'($urandom); req0_b = pend[0] ? pb[0] : W'($urandom);
      req0_sel = pend[0] ? ps[0] : S'($urandom);
      req1_a = pend[1] ? pa[1] : W'($urandom); req1_b = pend[1] ? pb[1] : W'($urandom);
      req1_sel = pend[1] ? ps[1] : S'($urandom);
      rdy0 = ($urandom_range(1, 0) == 1); rdy1 = ($urandom_range(1, 0) == 1);
      rsp0_ready = rdy0; rsp1_ready = rdy1;
      #1;
      tests++;
      if (ops_done !== C'(exp_ops)) begin
        fails++; $display("FAIL rnd_ops cyc%0d got %0d want %0d", cyc, ops_done, exp_ops);
      end
      if (phase == 0) begin
        if (pend[0] && pend[1]) eg = (mlast == 1) ? 0 : 1;
        else if (pend[0])       eg = 0;
        else if (pend[1])       eg = 1;
        else                    eg = -1;
        tests++;
        if ({req1_ready, req0_ready, busy, rsp1_valid, rsp0_valid} !==
            {eg == 1, eg == 0, 3'b000}) begin
          fails++; $display("FAIL rnd_idle cyc%0d rdy=%b busy=%b v=%b want grant %0d",
                            cyc, {req1_ready, req0_ready}, busy, {rsp1_valid, rsp0_valid}, eg);
        end
        if (eg >= 0) begin
          own = eg; ca = pa[eg]; cb = pb[eg]; cs = ps[eg];
          expv = alu_fn(ca, cb, cs);
          pend[eg] = 0;
          phase = 1;
        end
      end else if (phase == 1) begin
        tests++;
        if ({busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 5'b10000 ||
            {alu_a, alu_b, alu_sel} !== {ca, cb, cs}) begin
          fails++; $display("FAIL rnd_exec cyc%0d busy=%b a=%h b=%h sel=%h want %h %h %h",
                            cyc, busy, alu_a, alu_b, alu_sel, ca, cb, cs);
        end
        phase = 2;
      end else begin
        tests++;
        if ({rsp1_valid, rsp0_valid} !== (own == 1 ? 2'b10 : 2'b01) ||
            {req1_ready, req0_ready} !== 2'b00 || {rsp_cout, rsp_data} !== expv) begin
          fails++; $display("FAIL rnd_rsp cyc%0d v=%b rdy=%b c=%b d=%h want owner %0d c=%b d=%h",
                            cyc, {rsp1_valid, rsp0_valid}, {req1_ready, req0_ready},
                            rsp_cout, rsp_data, own, expv[W], expv[W-1:0]);
        end
        if ((own == 0 && rdy0) || (own == 1 && rdy1)) begin
          mlast = own;
          exp_ops = (exp_ops + 1) % 16;
          phase = 0;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
